// File: rtl/sao_stat_cate_sched.sv
// SAO statistics category scheduler: time-shares one two-pixel adder across all offset
// categories per beat, accumulates per-category (sum, count), then streams one record each.
module sao_stat_cate_sched #(
  parameter int NCAT          = 5,
  parameter int n_bo_type     = 5,
  parameter int diff_clip_bit = 4,
  parameter int ACC_W         = 18,
  parameter int CNT_W         = 11,
  parameter int BEAT_W        = 10
) (
  input  logic                            clk,
  input  logic                            arst,
  input  logic                            start,
  input  logic [BEAT_W-1:0]               num_beats,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [n_bo_type-1:0]            in_cate [0:1],
  output logic [n_bo_type-1:0]            cate_target,
  output logic                            en_stat,
  output logic                            working,
  input  logic signed [diff_clip_bit+1:0] s21,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [n_bo_type-1:0]            out_cate,
  output logic signed [ACC_W-1:0]         out_sum,
  output logic [CNT_W-1:0]                out_cnt,
  output logic                            done
);

  localparam int KW = (NCAT > 1) ? $clog2(NCAT) : 1;
  localparam logic [KW-1:0]           K_LAST  = KW'(NCAT - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, OUT} state_t;

  state_t                  state_q, state_d;
  logic [KW-1:0]           k, k_d, r;
  logic [BEAT_W-1:0]       beats_left;
  logic                    en_d;
  logic                    start_go;
  logic signed [ACC_W-1:0] acc [NCAT];
  logic [CNT_W-1:0]        cnt [NCAT];
  logic signed [ACC_W:0]   acc_sum;
  logic [CNT_W:0]          cnt_sum;
  logic [1:0]              hits;

  assign start_go = (state_q == IDLE) && start;

  // NOTE: every combinational output gets a default before the case so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    en_stat  = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = (num_beats == '0) ? DRAIN : SWEEP;
      SWEEP: begin
        en_stat = in_valid;
        if (in_valid && (k == K_LAST)) begin
          in_ready = 1'b1;
          if (beats_left == BEAT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: state_d = OUT;
      OUT:   if (out_ready && (r == K_LAST)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= IDLE;
      k          <= '0;
      k_d        <= '0;
      r          <= '0;
      beats_left <= '0;
      en_d       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q <= state_d;
      en_d    <= en_stat;
      k_d     <= k;
      done    <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          beats_left <= num_beats;
          k          <= '0;
        end
        SWEEP: if (in_valid) begin
          if (k == K_LAST) begin
            k          <= '0;
            beats_left <= beats_left - 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        DRAIN: r <= '0;
        OUT: if (out_ready) begin
          if (r == K_LAST) begin
            r    <= '0;
            done <= 1'b1;
          end else begin
            r <= r + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Adder result lands one cycle after its enable, so sums index by the delayed k.
  always_comb begin
    hits    = 2'(in_cate[0] == n_bo_type'(k)) + 2'(in_cate[1] == n_bo_type'(k));
    cnt_sum = {1'b0, cnt[k]} + (CNT_W+1)'(hits);
    acc_sum = (ACC_W+1)'(acc[k_d]) + (ACC_W+1)'(s21);
  end

  // NOTE: the per-category arrays are reset by arst so an aborted block can never surface in a read-out.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int c = 0; c < NCAT; c++) acc[c] <= '0;
    end else if (start_go) begin
      for (int c = 0; c < NCAT; c++) acc[c] <= '0;
    end else if (en_d) begin
      if (acc_sum[ACC_W] != acc_sum[ACC_W-1])
        acc[k_d] <= acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
      else
        acc[k_d] <= acc_sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int c = 0; c < NCAT; c++) cnt[c] <= '0;
    end else if (start_go) begin
      for (int c = 0; c < NCAT; c++) cnt[c] <= '0;
    end else if (en_stat) begin
      cnt[k] <= cnt_sum[CNT_W] ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end
  end

  assign working     = (state_q == SWEEP) || (state_q == DRAIN);
  assign cate_target = (state_q == SWEEP) ? n_bo_type'(k) : '0;
  assign out_valid   = (state_q == OUT);
  assign out_cate    = out_valid ? n_bo_type'(r) : '0;
  assign out_sum     = out_valid ? acc[r] : '0;
  assign out_cnt     = out_valid ? cnt[r] : '0;

endmodule

// File: tb/tb_sao_stat_cate_sched.sv
// Bench for sao_stat_cate_sched: a behavioural adder plus a per-block (sum, count) model
// derived from the beat data, checked against the streamed records and sweep handshakes.
module tb_sao_stat_cate_sched;

  localparam int NCAT    = 5;
  localparam int NBT     = 5;
  localparam int DCB     = 4;
  localparam int ACC_W   = 14;
  localparam int CNT_W   = 11;
  localparam int BEAT_W  = 10;
  localparam int SUM_MAX = (1 << (ACC_W - 1)) - 1;
  localparam int SUM_MIN = -(1 << (ACC_W - 1));
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                     clk = 1'b0;
  logic                     arst;
  logic                     start = 1'b0;
  logic [BEAT_W-1:0]        num_beats = '0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [NBT-1:0]           in_cate [0:1];
  logic [NBT-1:0]           cate_target;
  logic                     en_stat;
  logic                     working;
  logic signed [DCB+1:0]    s21 = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic [NBT-1:0]           out_cate;
  logic signed [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]         out_cnt;
  logic                     done;

  logic signed [DCB+1:0]    beat_s21  [1024][NCAT];
  logic [NBT-1:0]           beat_cate [1024][2];
  int                       exp_sum [NCAT];
  int                       exp_cnt [NCAT];
  int                       cur_beat = 0;
  int                       vectors = 0;
  int                       miscompares = 0;

  sao_stat_cate_sched #(
    .NCAT(NCAT), .n_bo_type(NBT), .diff_clip_bit(DCB),
    .ACC_W(ACC_W), .CNT_W(CNT_W), .BEAT_W(BEAT_W)
  ) dut (
    .clk(clk), .arst(arst), .start(start), .num_beats(num_beats),
    .in_valid(in_valid), .in_ready(in_ready), .in_cate(in_cate),
    .cate_target(cate_target), .en_stat(en_stat), .working(working), .s21(s21),
    .out_valid(out_valid), .out_ready(out_ready), .out_cate(out_cate),
    .out_sum(out_sum), .out_cnt(out_cnt), .done(done)
  );

  always #5 clk = ~clk;

  // Adder stand-in: returns the beat's value for the requested category one cycle later,
  // and noise whenever it is not enabled.
  always @(posedge clk) begin
    if (en_stat && int'(cate_target) < NCAT)
      s21 <= beat_s21[cur_beat][int'(cate_target)];
    else
      s21 <= (DCB+2)'($urandom);
  end

  task automatic fill_random(input int n);
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < NCAT; c++) beat_s21[b][c] = (DCB+2)'($urandom);
      beat_cate[b][0] = NBT'($urandom_range(0, 7));
      beat_cate[b][1] = NBT'($urandom_range(0, 7));
    end
  endtask

  // Expected records: in beat order, each category adds its adder value with clamping
  // and counts how many of the two pixels carry that category.
  task automatic compute_model(input int n);
    for (int c = 0; c < NCAT; c++) begin
      exp_sum[c] = 0;
      exp_cnt[c] = 0;
    end
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < NCAT; c++) begin
        exp_sum[c] += int'(beat_s21[b][c]);
        if (exp_sum[c] > SUM_MAX) exp_sum[c] = SUM_MAX;
        if (exp_sum[c] < SUM_MIN) exp_sum[c] = SUM_MIN;
        exp_cnt[c] += int'(beat_cate[b][0] == NBT'(c)) + int'(beat_cate[b][1] == NBT'(c));
        if (exp_cnt[c] > CNT_MAX) exp_cnt[c] = CNT_MAX;
      end
    end
  endtask

  task automatic run_block(input int n, input int stall_pct, input int ostall_pct,
                           input bit poke_start, input int fs_beat, input int fs_k,
                           input int exp_lat);
    int b, k, cyc, r, fs_left, hold, guard;
    bit fs_used, first_seen, finished;
    compute_model(n);
    @(negedge clk);
    start = 1'b1; num_beats = BEAT_W'(n); in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; num_beats = BEAT_W'($urandom);
    cyc = 1; b = 0; k = 0; fs_left = 0; fs_used = 1'b0;
    while (b < n && cyc < 20000) begin
      if (!fs_used && b == fs_beat && k == fs_k) begin
        fs_left = 2;
        fs_used = 1'b1;
      end
      if (fs_left > 0) begin
        in_valid = 1'b0;
        fs_left--;
      end else begin
        in_valid = ($urandom_range(99) >= stall_pct);
      end
      cur_beat = b;
      in_cate[0] = beat_cate[b][0];
      in_cate[1] = beat_cate[b][1];
      #1;
      vectors++;
      if (cate_target !== NBT'(k) || en_stat !== in_valid || working !== 1'b1 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL sweep beat %0d: cate_target=%0d en_stat=%b working=%b out_valid=%b, want %0d %b 1 0",
                 b, cate_target, en_stat, working, out_valid, k, in_valid);
      end
      vectors++;
      if (in_ready !== (in_valid && k == NCAT - 1)) begin
        miscompares++;
        $display("FAIL in_ready beat %0d k %0d: got %b want %b", b, k, in_ready, in_valid && k == NCAT - 1);
      end
      if (in_valid) begin
        if (k == NCAT - 1) begin
          k = 0;
          b++;
        end else begin
          k++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (b < n) begin
      vectors++;
      miscompares++;
      $display("FAIL sweep timeout: %0d of %0d beats consumed", b, n);
    end

    r = 0; hold = 0; first_seen = 1'b0; finished = 1'b0; guard = 0;
    while (!finished && guard < 400) begin
      in_valid   = 1'($urandom_range(1));
      in_cate[0] = NBT'($urandom);
      in_cate[1] = NBT'($urandom);
      cur_beat   = 0;
      if (poke_start && first_seen && r == 2 && hold < 3) begin
        out_ready = 1'b0;
        start     = 1'b1;
        num_beats = BEAT_W'($urandom_range(1, 5));
        hold++;
      end else begin
        out_ready = ($urandom_range(99) >= ostall_pct);
        start     = 1'b0;
      end
      #1;
      if (out_valid && !first_seen) begin
        first_seen = 1'b1;
        if (exp_lat >= 0) begin
          vectors++;
          if (cyc != exp_lat) begin
            miscompares++;
            $display("FAIL latency start->out_valid: got %0d want %0d", cyc, exp_lat);
          end
        end
      end
      vectors++;
      if (en_stat !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || working !== !first_seen) begin
        miscompares++;
        $display("FAIL drain/out control: en_stat=%b in_ready=%b done=%b working=%b, want 0 0 0 %b",
                 en_stat, in_ready, done, working, !first_seen);
      end
      if (out_valid) begin
        vectors++;
        if (out_cate !== NBT'(r) || int'(out_sum) != exp_sum[r] || int'(out_cnt) != exp_cnt[r]) begin
          miscompares++;
          $display("FAIL record %0d: got cate %0d sum %0d cnt %0d, want cate %0d sum %0d cnt %0d",
                   r, out_cate, out_sum, out_cnt, r, exp_sum[r], exp_cnt[r]);
        end
        if (out_ready) begin
          r++;
          if (r == NCAT) finished = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
      guard++;
    end
    start = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    #1;
    vectors++;
    if (!finished) begin
      miscompares++;
      $display("FAIL out timeout: %0d of %0d records transferred", r, NCAT);
    end else if (done !== 1'b1 || out_valid !== 1'b0 || working !== 1'b0) begin
      miscompares++;
      $display("FAIL done pulse: done=%b out_valid=%b working=%b, want 1 0 0", done, out_valid, working);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL done width: done=%b out_valid=%b, want 0 0", done, out_valid);
    end
  endtask

  task automatic test_reset;
    arst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_cate[0] = '0; in_cate[1] = '0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({in_ready, en_stat, working, out_valid, done, cate_target, out_cate, out_sum, out_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset outputs: in_ready=%b en_stat=%b working=%b out_valid=%b done=%b ct=%0d oc=%0d sum=%0d cnt=%0d, want all 0",
               in_ready, en_stat, working, out_valid, done, cate_target, out_cate, out_sum, out_cnt);
    end
    @(negedge clk);
    arst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    vectors++;
    if ({in_ready, en_stat, working, out_valid, done} !== '0) begin
      miscompares++;
      $display("FAIL idle after reset: in_ready=%b en_stat=%b working=%b out_valid=%b done=%b, want 0",
               in_ready, en_stat, working, out_valid, done);
    end
  endtask

  task automatic test_single_beat;
    for (int c = 0; c < NCAT; c++) beat_s21[0][c] = (c == 2) ? 6'sd3 : 6'sd0;
    beat_cate[0][0] = 5'd2;
    beat_cate[0][1] = 5'd2;
    run_block(1, 0, 0, 1'b0, -1, 0, 1 + NCAT + 1);
  endtask

  task automatic test_stall;
    fill_random(4);
    run_block(4, 0, 0, 1'b0, 1, 3, 1 + 22 + 1);
  endtask

  task automatic test_zero_beats;
    run_block(0, 0, 20, 1'b0, -1, 0, 2);
  endtask

  task automatic test_saturation;
    for (int b = 0; b < 1023; b++) begin
      beat_s21[b][0] = 6'sd31;
      beat_s21[b][1] = -6'sd32;
      for (int c = 2; c < NCAT; c++) beat_s21[b][c] = (DCB+2)'($urandom);
      beat_cate[b][0] = 5'd0;
      beat_cate[b][1] = 5'd0;
    end
    run_block(1023, 0, 0, 1'b0, -1, 0, 1 + NCAT * 1023 + 1);
  endtask

  task automatic test_out_backpressure;
    fill_random(3);
    run_block(3, 0, 0, 1'b1, -1, 0, 1 + NCAT * 3 + 1);
  endtask

  task automatic test_abort;
    int b, k;
    fill_random(4);
    @(negedge clk);
    start = 1'b1; num_beats = BEAT_W'(4);
    @(negedge clk);
    start = 1'b0;
    b = 0; k = 0;
    while (!(b == 2 && k == 3)) begin
      in_valid = 1'b1; cur_beat = b;
      in_cate[0] = beat_cate[b][0]; in_cate[1] = beat_cate[b][1];
      if (k == NCAT - 1) begin
        k = 0;
        b++;
      end else begin
        k++;
      end
      @(negedge clk);
    end
    arst = 1'b1;
    #1;
    vectors++;
    if ({in_ready, en_stat, working, out_valid, done, cate_target, out_cate, out_sum, out_cnt} !== '0) begin
      miscompares++;
      $display("FAIL abort outputs: in_ready=%b en_stat=%b working=%b out_valid=%b done=%b ct=%0d oc=%0d sum=%0d cnt=%0d, want all 0",
               in_ready, en_stat, working, out_valid, done, cate_target, out_cate, out_sum, out_cnt);
    end
    @(negedge clk);
    arst = 1'b0; in_valid = 1'b0;
    fill_random(3);
    run_block(3, 0, 0, 1'b0, -1, 0, 1 + NCAT * 3 + 1);
  endtask

  task automatic test_random;
    int n;
    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(1, 12);
      fill_random(n);
      run_block(n, 25, 30, 1'b0, -1, 0, -1);
    end
  endtask

  task automatic test_back_to_back;
    fill_random(3);
    run_block(3, 0, 0, 1'b0, -1, 0, 1 + NCAT * 3 + 1);
    fill_random(6);
    run_block(6, 0, 0, 1'b0, -1, 0, 1 + NCAT * 6 + 1);
  endtask

  initial begin
    in_cate[0] = '0;
    in_cate[1] = '0;
    test_reset;
    test_single_beat;
    test_stall;
    test_zero_beats;
    test_saturation;
    test_out_backpressure;
    test_abort;
    test_random;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
